// File: rtl/kypd_pkg.sv
// Shared constants, FSM state type and the 4x4 key map for the keypad emulator.
package kypd_pkg;

  localparam logic [3:0] ROW_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } kypd_state_e;

  // Column strobe (active low) that scans the given key
  function automatic logic [3:0] key_col(input logic [3:0] code);
    case (code)
      4'h1, 4'h4, 4'h7, 4'h0: key_col = 4'b0111;
      4'h2, 4'h5, 4'h8, 4'hF: key_col = 4'b1011;
      4'h3, 4'h6, 4'h9, 4'hE: key_col = 4'b1101;
      default:                key_col = 4'b1110;
    endcase
  endfunction

  // Row line (active low) the key pulls when its column is strobed
  function automatic logic [3:0] key_row(input logic [3:0] code);
    case (code)
      4'h1, 4'h2, 4'h3, 4'hA: key_row = 4'b0111;
      4'h4, 4'h5, 4'h6, 4'hB: key_row = 4'b1011;
      4'h7, 4'h8, 4'h9, 4'hC: key_row = 4'b1101;
      default:                key_row = 4'b1110;
    endcase
  endfunction

endpackage

// File: rtl/kypd_col_sync.sv
// Two-flop synchronizer for the scanner column strobes, with a per-bit
// falling-edge (column asserted) strobe taken on the synchronized value.
module kypd_col_sync
  import kypd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] col_s,
  output logic [3:0] col_fall
);

  logic [3:0] col_q1;
  logic [3:0] col_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q1 <= ROW_IDLE;
      col_s  <= ROW_IDLE;
      col_d  <= ROW_IDLE;
    end else begin
      col_q1 <= col;
      col_s  <= col_q1;
      col_d  <= col_s;
    end
  end

  assign col_fall = col_d & ~col_s;

endmodule

// File: rtl/kypd_emulator.sv
// Keypad-side emulator: answers the scanner's column strobes with the row of a
// commanded key for HOLD_SCANS strobes, then idles Row for RELEASE_CYCLES.
//
// state   | meaning
// IDLE    | Row idle, key_ready high, waiting for a command
// PRESS   | answering strobes of the key's column, counting scans and timeout
// RELEASE | Row idle for RELEASE_CYCLES, then key_done and back to IDLE
module kypd_emulator
  import kypd_pkg::*;
#(
  parameter int HOLD_SCANS     = 2,
  parameter int RELEASE_CYCLES = 100000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Col,
  output logic [3:0] Row,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic       key_done,
  output logic       key_timeout
);

  localparam int SCAN_W = $clog2(HOLD_SCANS) + 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int REL_W  = $clog2(RELEASE_CYCLES) + 1;

  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(HOLD_SCANS);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [REL_W-1:0]  REL_LAST = REL_W'(RELEASE_CYCLES - 1);
  localparam logic [REL_W-1:0]  REL_END  = REL_W'(RELEASE_CYCLES);

  kypd_state_e       state;
  logic [3:0]        col_pat;
  logic [3:0]        row_pat;
  logic [SCAN_W-1:0] scan_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [REL_W-1:0]  rel_cnt;

  logic [3:0] col_s;
  logic [3:0] col_fall;
  logic       col_match;
  logic       col_event;
  logic       release_hit;
  logic       timeout_hit;

  kypd_col_sync u_col_sync (
    .clk      (clk),
    .rst      (rst),
    .col      (Col),
    .col_s    (col_s),
    .col_fall (col_fall)
  );

  assign key_ready   = (state == IDLE) && !rst;
  assign col_match   = (col_s == col_pat);
  // Exact match plus a fall on the key's own column bit marks a new strobe
  assign col_event   = col_match && |(col_fall & ~col_pat);
  assign release_hit = (scan_cnt == SCAN_MAX) && !col_match;
  assign timeout_hit = (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      Row         <= ROW_IDLE;
      col_pat     <= ROW_IDLE;
      row_pat     <= ROW_IDLE;
      scan_cnt    <= '0;
      to_cnt      <= '0;
      rel_cnt     <= '0;
      key_done    <= 1'b0;
      key_timeout <= 1'b0;
    end else begin
      key_done    <= 1'b0;
      key_timeout <= 1'b0;
      case (state)
        IDLE: begin
          Row <= ROW_IDLE;
          if (key_valid && key_ready) begin
            col_pat  <= key_col(key_code);
            row_pat  <= key_row(key_code);
            scan_cnt <= '0;
            to_cnt   <= '0;
            state    <= PRESS;
          end
        end
        PRESS: begin
          if (release_hit) begin
            Row     <= ROW_IDLE;
            rel_cnt <= '0;
            state   <= RELEASE;
          end else if (timeout_hit) begin
            Row         <= ROW_IDLE;
            rel_cnt     <= '0;
            key_timeout <= 1'b1;
            state       <= RELEASE;
          end else begin
            Row <= col_match ? row_pat : ROW_IDLE;
            if (col_event) begin
              to_cnt <= '0;
              if (scan_cnt != SCAN_MAX) scan_cnt <= scan_cnt + 1'b1;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        RELEASE: begin
          Row <= ROW_IDLE;
          // key_done goes out while still in RELEASE so key_ready rises one cycle later
          if (rel_cnt == REL_END) begin
            state <= IDLE;
          end else begin
            if (rel_cnt == REL_LAST) key_done <= 1'b1;
            rel_cnt <= rel_cnt + 1'b1;
          end
        end
        default: begin
          Row   <= ROW_IDLE;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kypd_emulator.sv
// Directed bench for kypd_emulator: table of key presses against a compressed
// scanner (40 cycles per column), plus timeout, reset, busy and back-to-back cases.
module tb_kypd_emulator;

  localparam int HOLD  = 2;
  localparam int REL   = 50;
  localparam int TMO   = 500;
  localparam int MAXC  = 600;
  localparam int SCANC = 480;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] Col;
  logic [3:0] Row;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       key_done;
  logic       key_timeout;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] drv_col [MAXC];

  typedef struct {
    logic [3:0] code;
    logic [3:0] kcol;
    logic [3:0] krow;
  } vec_t;

  vec_t vecs [10];

  kypd_emulator #(
    .HOLD_SCANS     (HOLD),
    .RELEASE_CYCLES (REL),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Col         (Col),
    .Row         (Row),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .key_done    (key_done),
    .key_timeout (key_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic build_scan();
    logic [3:0] pat [4];
    pat = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    for (int i = 0; i < SCANC; i++) drv_col[i] = pat[(i / 40) % 4];
  endtask

  // Press one key and drive drv_col[0..ncyc-1]; expected Row is the key's row
  // three cycles after each of the first HOLD strobes of its column.
  task automatic run_press(input logic [3:0] code, input logic [3:0] kc,
                           input logic [3:0] kr, input int ncyc, input int busy_at);
    int sn [MAXC];
    int n_strobe, done_at, done_cnt;
    logic [3:0] prev, exp_row;
    prev = 4'hF; n_strobe = 0; done_at = -1; done_cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (drv_col[i] == kc && prev != kc) n_strobe++;
      sn[i] = (drv_col[i] == kc) ? n_strobe : 0;
      if (done_at < 0 && n_strobe == HOLD && drv_col[i] != kc) done_at = i + 3 + REL;
      prev = drv_col[i];
    end
    @(negedge clk);
    chk($sformatf("ready before k%h", code), {3'b0, key_ready}, 4'h1);
    key_code  = code;
    key_valid = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      key_valid = (c == busy_at);
      if (c == busy_at) key_code = 4'h3;
      Col = drv_col[c];
      @(negedge clk);
      exp_row = (c >= 3 && sn[c-3] >= 1 && sn[c-3] <= HOLD) ? kr : 4'hF;
      chk($sformatf("row k%h c%0d", code, c), Row, exp_row);
      chk($sformatf("done k%h c%0d", code, c), {3'b0, key_done}, {3'b0, (c == done_at)});
      chk($sformatf("tmo k%h c%0d", code, c), {3'b0, key_timeout}, 4'h0);
      if (c == busy_at) chk($sformatf("busy ready k%h", code), {3'b0, key_ready}, 4'h0);
      if (key_done) done_cnt++;
    end
    chk($sformatf("done count k%h", code), 4'(done_cnt), 4'h1);
    key_valid = 1'b0;
    Col = 4'hF;
  endtask

  initial begin
    int done_t;
    int seen8, seen2;
    rst = 1'b1; Col = 4'hF; key_valid = 1'b0; key_code = 4'h0;

    vecs[0] = '{4'h5, 4'b1011, 4'b1011};
    vecs[1] = '{4'h0, 4'b0111, 4'b1110};
    vecs[2] = '{4'hD, 4'b1110, 4'b1110};
    vecs[3] = '{4'h1, 4'b0111, 4'b0111};
    vecs[4] = '{4'h9, 4'b1101, 4'b1101};
    vecs[5] = '{4'hF, 4'b1011, 4'b1110};
    vecs[6] = '{4'hA, 4'b1110, 4'b0111};
    vecs[7] = '{4'h7, 4'b0111, 4'b1101};
    vecs[8] = '{4'h6, 4'b1101, 4'b1011};
    vecs[9] = '{4'hC, 4'b1110, 4'b1101};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst row", Row, 4'hF);
    chk("rst done", {3'b0, key_done}, 4'h0);
    chk("rst tmo", {3'b0, key_timeout}, 4'h0);
    chk("rst ready", {3'b0, key_ready}, 4'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready after rst", {3'b0, key_ready}, 4'h1);

    // Table of single presses against the full scan
    build_scan();
    foreach (vecs[i]) run_press(vecs[i].code, vecs[i].kcol, vecs[i].krow, SCANC, -1);

    // Key 3 pulsed while key A is pressed must not be queued
    run_press(4'hA, 4'b1110, 4'b0111, SCANC, 50);

    // Illegal multi-low column must not count as a scan of key 1
    for (int i = 0; i < 300; i++)
      drv_col[i] = (i < 40) ? 4'b0011 :
                   ((i >= 80 && i < 120) || (i >= 160 && i < 200)) ? 4'b0111 : 4'b1111;
    run_press(4'h1, 4'b0111, 4'b0111, 300, -1);

    // Timeout: key 9 with no strobes
    @(negedge clk);
    key_code = 4'h9; key_valid = 1'b1;
    for (int k = 0; k <= 560; k++) begin
      @(posedge clk); #1 key_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("tmo pulse k%0d", k), {3'b0, key_timeout}, {3'b0, (k == TMO)});
      chk($sformatf("tmo done k%0d", k), {3'b0, key_done}, {3'b0, (k == TMO + REL)});
      chk($sformatf("tmo row k%0d", k), Row, 4'hF);
      if (k == 0 || k == TMO + REL || k == TMO + REL + 1)
        chk($sformatf("tmo ready k%0d", k), {3'b0, key_ready}, {3'b0, (k > TMO + REL)});
    end

    // Reset in the middle of a press of key B
    @(negedge clk);
    key_code = 4'hB; key_valid = 1'b1;
    @(posedge clk); #1 key_valid = 1'b0; Col = 4'b1110;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("rstmid row before", Row, 4'b1011);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid row", Row, 4'hF);
    chk("rstmid ready", {3'b0, key_ready}, 4'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid ready after", {3'b0, key_ready}, 4'h1);
    Col = 4'hF;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      chk($sformatf("rstmid nodone %0d", k), {3'b0, key_done}, 4'h0);
    end

    // Back-to-back: key 2 then key 8 with key_valid held
    @(negedge clk);
    key_code = 4'h2; key_valid = 1'b1;
    done_t = -1;
    for (int t = 0; t < 1000 && done_t < 0; t++) begin
      @(posedge clk); #1 Col = ((t / 20) % 2 == 0) ? 4'b1011 : 4'hF;
      @(negedge clk);
      if (key_done) done_t = t;
    end
    n_cmp++;
    if (done_t < 0) begin
      n_err++;
      $display("FAIL b2b first done actual=none required=pulse");
    end
    chk("b2b ready at done", {3'b0, key_ready}, 4'h0);
    key_code = 4'h8;
    @(posedge clk); #1 Col = 4'hF;
    @(negedge clk);
    chk("b2b ready after done", {3'b0, key_ready}, 4'h1);
    @(posedge clk); #1 key_valid = 1'b0;
    @(negedge clk);
    chk("b2b accepted", {3'b0, key_ready}, 4'h0);
    done_t = -1; seen8 = 0; seen2 = 0;
    for (int t = 0; t < 1000 && done_t < 0; t++) begin
      @(posedge clk); #1 Col = ((t / 20) % 2 == 1) ? 4'b1011 : 4'hF;
      @(negedge clk);
      if (Row == 4'b1101) seen8 = 1;
      if (Row == 4'b0111) seen2 = 1;
      if (key_done) done_t = t;
    end
    chk("b2b key8 row seen", 4'(seen8), 4'h1);
    chk("b2b key2 row absent", 4'(seen2), 4'h0);
    n_cmp++;
    if (done_t < 0) begin
      n_err++;
      $display("FAIL b2b second done actual=none required=pulse");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=running required=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
